// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready word side, one-word holding buffer and defined idle level.
// Optional even-parity trailer bit per frame when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int unsigned WORD_W     = 10,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic              CLK_IN,
    input  logic              RESET_IN,
    input  logic [WORD_W-1:0] PAR_DATA_IN,
    input  logic              PAR_VALID_IN,
    output logic              PAR_READY_OUT,
    output logic              SERIAL_OUT,
    output logic              FRAME_START_OUT,
    output logic              UNDERRUN_OUT,
    output logic              BUSY_OUT
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FL = WORD_W + 1;
`else
    localparam int unsigned FL = WORD_W;
`endif
    localparam int unsigned   CNT_W    = $clog2(FL);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              state;
    logic [FL-1:0]       sr;
    logic [WORD_W-1:0]   hold;
    logic                hold_valid;
    logic [CNT_W-1:0]    bit_cnt;
    logic                underrun_pend;

    logic                xfer_c;
    logic                load_pt_c;
    logic                head_bit_c;
    logic [FL-1:0]       sr_shifted_c;

    // Frame image as loaded into SR: the head bit sits at the end the shifter drains from.
    function automatic logic [FL-1:0] frame_of(input logic [WORD_W-1:0] w);
`ifdef PISO_PARITY_EN
        if (LSB_FIRST) begin
            return {^w, w};
        end
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    assign PAR_READY_OUT = !hold_valid && !RESET_IN;
    assign xfer_c        = PAR_VALID_IN && PAR_READY_OUT;
    assign load_pt_c     = (state == ST_IDLE) || (bit_cnt == LAST_BIT);
    assign head_bit_c    = LSB_FIRST ? sr[0] : sr[FL-1];
    assign sr_shifted_c  = LSB_FIRST ? {1'b0, sr[FL-1:1]} : {sr[FL-2:0], 1'b0};

    // Line outputs reflect the current state; state/buffer advance by the load rule.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state           <= ST_IDLE;
            sr              <= '0;
            hold            <= '0;
            hold_valid      <= 1'b0;
            bit_cnt         <= '0;
            underrun_pend   <= 1'b0;
            SERIAL_OUT      <= IDLE_LEVEL;
            FRAME_START_OUT <= 1'b0;
            UNDERRUN_OUT    <= 1'b0;
            BUSY_OUT        <= 1'b0;
        end else begin
            if (state == ST_SHIFT) begin
                SERIAL_OUT      <= head_bit_c;
                FRAME_START_OUT <= (bit_cnt == '0);
                BUSY_OUT        <= 1'b1;
                UNDERRUN_OUT    <= 1'b0;
            end else begin
                SERIAL_OUT      <= IDLE_LEVEL;
                FRAME_START_OUT <= 1'b0;
                BUSY_OUT        <= 1'b0;
                UNDERRUN_OUT    <= underrun_pend;
            end

            if (load_pt_c) begin
                if (hold_valid) begin
                    sr            <= frame_of(hold);
                    hold_valid    <= xfer_c;
                    if (xfer_c) begin
                        hold <= PAR_DATA_IN;
                    end
                    state         <= ST_SHIFT;
                    bit_cnt       <= '0;
                    underrun_pend <= 1'b0;
                end else if (xfer_c) begin
                    sr            <= frame_of(PAR_DATA_IN);
                    state         <= ST_SHIFT;
                    bit_cnt       <= '0;
                    underrun_pend <= 1'b0;
                end else begin
                    state         <= ST_IDLE;
                    underrun_pend <= (state == ST_SHIFT);
                end
            end else begin
                sr      <= sr_shifted_c;
                bit_cnt <= bit_cnt + CNT_ONE;
                if (xfer_c) begin
                    hold       <= PAR_DATA_IN;
                    hold_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: two instances (LSB-first/idle 0, MSB-first/idle 1) share one stimulus.
module tb_piso_serializer;

    localparam int unsigned W = 10;
`ifdef PISO_PARITY_EN
    localparam int unsigned FL = W + 1;
`else
    localparam int unsigned FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data;
    logic         valid;
    logic         ready_a, ready_b, ser_a, ser_b, fs_a, fs_b, ur_a, ur_b, busy_a, busy_b;

    always #5 clk = ~clk;

    piso_serializer #(.WORD_W(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .CLK_IN(clk), .RESET_IN(rst), .PAR_DATA_IN(data), .PAR_VALID_IN(valid),
        .PAR_READY_OUT(ready_a), .SERIAL_OUT(ser_a), .FRAME_START_OUT(fs_a),
        .UNDERRUN_OUT(ur_a), .BUSY_OUT(busy_a));

    piso_serializer #(.WORD_W(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
        .CLK_IN(clk), .RESET_IN(rst), .PAR_DATA_IN(data), .PAR_VALID_IN(valid),
        .PAR_READY_OUT(ready_b), .SERIAL_OUT(ser_b), .FRAME_START_OUT(fs_b),
        .UNDERRUN_OUT(ur_b), .BUSY_OUT(busy_b));

    // One scheduled line bit: value for each bit order, frame-start flag, cycle it must appear.
    typedef struct {
        logic        b_lsb;
        logic        b_msb;
        logic        first;
        int unsigned at;
    } ent_t;

    ent_t         q[$];
    ent_t         mon_e;
    int unsigned  cyc       = 0;
    int unsigned  n_chk     = 0;
    int unsigned  n_pass    = 0;
    int unsigned  line_free = 0;
    int unsigned  last_load = 0;
    logic         pending   = 1'b0;
    logic [W-1:0] pend_word = '0;
    logic         prev_busy = 1'b0;
    logic [W-1:0] cur_word;

    function automatic void check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    endfunction

    // Frame starts one cycle after acceptance, or right after the previous frame if still busy.
    function automatic void push_word(input logic [W-1:0] w, input int unsigned acc);
        int unsigned start;
        logic        par;
        ent_t        e;
        start = (acc + 1 > line_free) ? acc + 1 : line_free;
        par   = ^w;
        for (int unsigned i = 0; i < FL; i++) begin
            if (i < W) begin
                e.b_lsb = w[i];
                e.b_msb = w[W-1-i];
            end else begin
                e.b_lsb = par;
                e.b_msb = par;
            end
            e.first = (i == 0);
            e.at    = start + i;
            q.push_back(e);
        end
        line_free = start + FL;
        last_load = start - 1;
    endfunction

    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        int unsigned edge_n;
        logic        exp_rdy;
        @(posedge clk);
        #1;
        edge_n = cyc + 1;
        if (pending) push_word(pend_word, edge_n);
        rst = r;
        if (r) begin
            q.delete();
            line_free = 0;
            last_load = 0;
        end
        valid = v;
        data  = d;
        #1;
        exp_rdy = !r && !(last_load > edge_n);
        check("ready_a", ready_a, exp_rdy);
        check("ready_b", ready_b, exp_rdy);
        if (r) begin
            check("rst_ser_a", ser_a, 1'b0);
            check("rst_ser_b", ser_b, 1'b1);
            check("rst_busy_a", busy_a, 1'b0);
            check("rst_busy_b", busy_b, 1'b0);
        end
        pending   = v && exp_rdy;
        pend_word = d;
    endtask

    task automatic send(input logic [W-1:0] w);
        int unsigned n;
        n = 0;
        do begin
            step(1'b1, w, 1'b0);
            n++;
        end while (!pending && n < 64);
        check("accept", pending, 1'b1);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    // Line monitor: pops the scoreboard whenever a bit is due, otherwise expects idle level.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("busy_a", busy_a, 1'b0);  check("busy_b", busy_b, 1'b0);
            check("ser_a", ser_a, 1'b0);    check("ser_b", ser_b, 1'b1);
            check("fs_a", fs_a, 1'b0);      check("fs_b", fs_b, 1'b0);
            check("ur_a", ur_a, 1'b0);      check("ur_b", ur_b, 1'b0);
            prev_busy = 1'b0;
        end else if (q.size() > 0 && q[0].at <= cyc) begin
            mon_e = q.pop_front();
            check("busy_a", busy_a, 1'b1);      check("busy_b", busy_b, 1'b1);
            check("ser_a", ser_a, mon_e.b_lsb); check("ser_b", ser_b, mon_e.b_msb);
            check("fs_a", fs_a, mon_e.first);   check("fs_b", fs_b, mon_e.first);
            check("ur_a", ur_a, 1'b0);          check("ur_b", ur_b, 1'b0);
            prev_busy = 1'b1;
        end else begin
            check("busy_a", busy_a, 1'b0);  check("busy_b", busy_b, 1'b0);
            check("ser_a", ser_a, 1'b0);    check("ser_b", ser_b, 1'b1);
            check("fs_a", fs_a, 1'b0);      check("fs_b", fs_b, 1'b0);
            check("ur_a", ur_a, prev_busy); check("ur_b", ur_b, prev_busy);
            prev_busy = 1'b0;
        end
    end

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;
        repeat (3) step(1'b0, '0, 1'b1);
        idle(20);

        send(10'h2C5);
        idle(20);

        for (int unsigned i = 0; i < 8; i++) send((i % 2 == 0) ? 10'h3FF : 10'h000);
        idle(20);

        send(10'h200);
        idle(15);

`ifdef PISO_PARITY_EN
        send(10'h007);
        idle(15);
        send(10'h003);
        idle(15);
`endif

        send(10'h155);
        send(10'h0AA);
        repeat (3) step(1'b0, '0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1);
        idle(5);
        send(10'h3A5);
        idle(20);

        cur_word = W'($urandom);
        for (int unsigned i = 0; i < 600; i++) begin
            step(($urandom_range(3) != 0) || (i % 100 < 50), cur_word, 1'b0);
            if (pending) cur_word = W'($urandom);
        end
        step(1'b0, '0, 1'b0);

        for (int unsigned i = 0; i < 200 && q.size() > 0; i++) step(1'b0, '0, 1'b0);
        check("drained", q.size() == 0, 1'b1);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready word interface, a one-word holding buffer for gap-free streaming, selectable bit order and a defined idle line level. It sits between the PMA word-side logic and the serial line driver and supersedes the fixed 10:1 free-running PISO. It only takes a word when one is offered and reports underruns instead of shifting stale data.

## Interface
- WORD_W, 10, parallel word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 transmitted first, 0 = bit WORD_W-1 first.
- IDLE_LEVEL, 1'b0, value driven on SERIAL_OUT when no word is being shifted.
- CLK_IN  in  1  serial bit clock; all state changes on the rising edge.
- RESET_IN  in  1  reset, asynchronous, active-high; clock CLK_IN.
- PAR_DATA_IN  in  WORD_W  word to serialize; sampled when PAR_VALID_IN && PAR_READY_OUT.
- PAR_VALID_IN  in  1  word-side offer.
- PAR_READY_OUT  out  1  holding buffer empty; equals !hold_valid && !RESET_IN.
- SERIAL_OUT  out  1  serial data, registered.
- FRAME_START_OUT  out  1  registered; high exactly during the first bit of each frame.
- UNDERRUN_OUT  out  1  registered one-cycle pulse when a frame ends with no next word available.
- BUSY_OUT  out  1  registered; high while in SHIFT.

## Operation
- Storage: shift register SR (frame length FL bits), holding register HOLD (WORD_W) plus hold_valid, bit counter bit_cnt (clog2(FL) bits), state IDLE/SHIFT. FL = WORD_W, or WORD_W+1 with parity (see Configuration).
- Handshake: transfer when PAR_VALID_IN && PAR_READY_OUT on a rising edge. PAR_DATA_IN may change freely otherwise. When not ready, the offer is ignored and the word-side must hold it.
- Load point: the cycle when state==IDLE, or state==SHIFT with bit_cnt==FL-1 (last bit). At a load point:
  - if hold_valid: SR<=HOLD, hold_valid<=0, state<=SHIFT, bit_cnt<=0;
  - else if a transfer occurs this edge: the word bypasses HOLD straight into SR, with the same effect;
  - else: state<=IDLE. If the previous state was SHIFT, UNDERRUN_OUT pulses for one cycle.
- Transfer not at a load point: word goes to HOLD, hold_valid<=1.
- A transfer and a HOLD->SR load on the same edge: the old HOLD content goes to SR and the new word goes to HOLD, so hold_valid stays 1.
- SHIFT: SERIAL_OUT<=current bit selected by LSB_FIRST, bit_cnt increments, wraps at FL-1 through the load rule.
- IDLE: SERIAL_OUT<=IDLE_LEVEL.
- Reset (any time, including mid-frame): state IDLE, SR/HOLD/hold_valid/bit_cnt cleared, SERIAL_OUT=IDLE_LEVEL, FRAME_START_OUT=0, UNDERRUN_OUT=0, BUSY_OUT=0, PAR_READY_OUT=0 while asserted. The partial frame is discarded with no underrun pulse.

## Timing
- Latency: a word accepted from IDLE at edge N has its first bit on SERIAL_OUT after edge N+1. FRAME_START_OUT and BUSY_OUT are high from the same edge.
- Throughput: one bit per CLK_IN. Back-to-back frames are gap-free provided HOLD is filled before the last bit of the current frame (FL-1 cycles of slack).
- PAR_READY_OUT drops the cycle after HOLD fills. It rises the cycle after HOLD is drained into SR.
- UNDERRUN_OUT is asserted in the first IDLE_LEVEL cycle following the last bit.
- First cycle after reset release: PAR_READY_OUT=1, a transfer may occur.

## Configuration
- PISO_PARITY_EN defined: FL=WORD_W+1; an even-parity bit (XOR of the word) is appended as the last bit of every frame regardless of LSB_FIRST, and load/underrun rules apply at bit FL-1.
- PISO_PARITY_EN undefined: FL=WORD_W, with no parity logic synthesized.

## Test plan
- Reset then idle, no valid: SERIAL_OUT=IDLE_LEVEL, BUSY_OUT=0, UNDERRUN_OUT never pulses, PAR_READY_OUT=1.
- WORD_W=10, LSB_FIRST=1, single word 10'h2C5: serial sequence 1,0,1,0,0,0,1,1,0,1, FRAME_START_OUT on the first bit only, then one UNDERRUN_OUT pulse and return to IDLE_LEVEL.
- Continuous stream of 10'h3FF and 10'h000 with valid held high: no idle gaps, PAR_READY_OUT low whenever HOLD is full, no underrun until valid drops.
- LSB_FIRST=0, word 10'h200: first transmitted bit is 1, the remaining nine are 0.
- RESET_IN asserted at bit 4 of a frame with HOLD full: SERIAL_OUT=IDLE_LEVEL immediately, hold_valid cleared, no underrun; next accepted word transmits cleanly.
- PISO_PARITY_EN, WORD_W=10, word 10'h007: 11-bit frame ending in parity bit 1; word 10'h003 ends in parity bit 0.
